alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Single-issue ARM data-processing sequencer: condition check, timed ALU operand hold,
// NZCV update and a ready/valid register writeback.
module alu_sequencer #(
   parameter int unsigned ALU_WAIT  = 1,
   parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [3:0]  REQ_COND,
   input  logic [3:0]  REQ_OPCODE,
   input  logic        REQ_S,
   input  logic [3:0]  REQ_RD,
   input  logic [31:0] REQ_RN,
   input  logic [31:0] REQ_SHOP,
   input  logic        REQ_SHC,
   output logic [3:0]  ALU_FN,
   output logic [31:0] ALU_LEFT,
   output logic [31:0] ALU_RIGHT,
   output logic        ALU_CIN,
   input  logic [31:0] ALU_RES,
   input  logic        ALU_N,
   input  logic        ALU_Z,
   input  logic        ALU_C,
   input  logic        ALU_V,
   output logic        WB_VALID,
   input  logic        WB_READY,
   output logic [3:0]  WB_RD,
   output logic [31:0] WB_DATA,
   output logic [3:0]  FLAGS,
   input  logic        FLAGS_LD,
   input  logic [3:0]  FLAGS_IN,
   output logic        DONE,
   output logic        BUSY
);

   // A zero wait still needs one EXEC cycle for the ALU to settle.
   localparam int unsigned WaitEff  = (ALU_WAIT == 0) ? 1 : ALU_WAIT;
   localparam logic [3:0]  WaitLoad = 4'(WaitEff - 1);

   typedef enum logic [1:0] {
      StIdle,
      StEval,
      StExec,
      StWb
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cond_q, cond_d;
   logic        s_q, s_d;
   logic [3:0]  rd_q, rd_d;
   logic        shc_q, shc_d;
   logic [3:0]  alu_fn_q, alu_fn_d;
   logic [31:0] alu_left_q, alu_left_d;
   logic [31:0] alu_right_q, alu_right_d;
   logic        alu_cin_q, alu_cin_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [3:0]  flags_q, flags_d;

   logic        done;
   logic        is_cmp;
   logic        is_arith;
   logic        cond_ok;
   logic        upd_flags;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      logic ok;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond)
         4'h0:    ok = z;
         4'h1:    ok = ~z;
         4'h2:    ok = c;
         4'h3:    ok = ~c;
         4'h4:    ok = n;
         4'h5:    ok = ~n;
         4'h6:    ok = v;
         4'h7:    ok = ~v;
         4'h8:    ok = c & ~z;
         4'h9:    ok = ~c | z;
         4'hA:    ok = (n == v);
         4'hB:    ok = (n != v);
         4'hC:    ok = ~z & (n == v);
         4'hD:    ok = z | (n != v);
         4'hE:    ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   always_comb begin : decode
      // TST/TEQ/CMP/CMN: flag-only, never written back.
      is_cmp    = (alu_fn_q[3:2] == 2'b10);
      // SUB..RSC (2..7) and CMP/CMN (10, 11) take C and V from the ALU.
      is_arith  = (~alu_fn_q[3] & (alu_fn_q[2] | alu_fn_q[1])) | (alu_fn_q[3:1] == 3'b101);
      cond_ok   = cond_pass(cond_q, flags_q);
      upd_flags = s_q | is_cmp;
   end

   always_comb begin : next_state
      state_d     = state_q;
      cond_d      = cond_q;
      s_d         = s_q;
      rd_d        = rd_q;
      shc_d       = shc_q;
      alu_fn_d    = alu_fn_q;
      alu_left_d  = alu_left_q;
      alu_right_d = alu_right_q;
      alu_cin_d   = alu_cin_q;
      cnt_d       = cnt_q;
      wb_data_d   = wb_data_q;
      flags_d     = flags_q;
      done        = 1'b0;

      // External load first so a flag-setting capture below overrides it.
      if (FLAGS_LD) begin
         flags_d = FLAGS_IN;
      end

      case (state_q)
         StIdle: begin
            if (REQ_VALID) begin
               state_d     = StEval;
               cond_d      = REQ_COND;
               s_d         = REQ_S;
               rd_d        = REQ_RD;
               shc_d       = REQ_SHC;
               alu_fn_d    = REQ_OPCODE;
               alu_left_d  = REQ_RN;
               alu_right_d = REQ_SHOP;
            end
         end
         StEval: begin
            if (cond_ok) begin
               state_d   = StExec;
               cnt_d     = WaitLoad;
               alu_cin_d = flags_q[1];
            end else begin
               state_d = StIdle;
               done    = 1'b1;
            end
         end
         StExec: begin
            if (cnt_q == 4'd0) begin
               if (upd_flags) begin
                  flags_d = is_arith ? {ALU_N, ALU_Z, ALU_C, ALU_V}
                                     : {ALU_N, ALU_Z, shc_q, flags_q[0]};
               end
               if (is_cmp) begin
                  state_d = StIdle;
                  done    = 1'b1;
               end else begin
                  state_d   = StWb;
                  wb_data_d = ALU_RES;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StWb: begin
            if (WB_READY) begin
               state_d = StIdle;
               done    = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StIdle;
         cond_q      <= 4'd0;
         s_q         <= 1'b0;
         rd_q        <= 4'd0;
         shc_q       <= 1'b0;
         alu_fn_q    <= 4'd0;
         alu_left_q  <= 32'd0;
         alu_right_q <= 32'd0;
         alu_cin_q   <= 1'b0;
         cnt_q       <= 4'd0;
         wb_data_q   <= 32'd0;
         flags_q     <= FLAGS_RST;
      end else begin
         state_q     <= state_d;
         cond_q      <= cond_d;
         s_q         <= s_d;
         rd_q        <= rd_d;
         shc_q       <= shc_d;
         alu_fn_q    <= alu_fn_d;
         alu_left_q  <= alu_left_d;
         alu_right_q <= alu_right_d;
         alu_cin_q   <= alu_cin_d;
         cnt_q       <= cnt_d;
         wb_data_q   <= wb_data_d;
         flags_q     <= flags_d;
      end
   end

   assign REQ_READY = (state_q == StIdle);
   assign BUSY      = (state_q != StIdle);
   assign WB_VALID  = (state_q == StWb);
   assign WB_RD     = rd_q;
   assign WB_DATA   = wb_data_q;
   assign ALU_FN    = alu_fn_q;
   assign ALU_LEFT  = alu_left_q;
   assign ALU_RIGHT = alu_right_q;
   assign ALU_CIN   = alu_cin_q;
   assign FLAGS     = flags_q;
   assign DONE      = done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, randomized transactions against a
// behavioural model, and reset-in-flight on a long-wait instance.
module tb_alu_sequencer;

   localparam int W  = 1;
   localparam int W4 = 4;

   typedef struct {
      logic [3:0]  pre;
      logic [3:0]  cond;
      logic [3:0]  op;
      logic        s;
      logic [3:0]  rd;
      logic [31:0] rn;
      logic [31:0] shop;
      logic        shc;
      int          dly;
      logic        ld_cap;
      logic        exp_wb;
      logic [31:0] exp_data;
      logic [3:0]  exp_flags;
      int          exp_done;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic        clk, rst;
   logic        req_valid, req_ready, req_s, req_shc;
   logic [3:0]  req_cond, req_opcode, req_rd;
   logic [31:0] req_rn, req_shop;
   logic [3:0]  alu_fn;
   logic [31:0] alu_left, alu_right, alu_res;
   logic        alu_cin, alu_n, alu_z, alu_c, alu_v;
   logic        wb_valid, wb_ready, flags_ld, done, busy;
   logic [3:0]  wb_rd, flags, flags_in;
   logic [31:0] wb_data;
   logic [35:0] alu_out;

   logic        rst4, req_valid4, req_ready4, wb_ready4, flags_ld4, done4, busy4;
   logic [3:0]  alu_fn4, wb_rd4, flags4, flags_in4;
   logic [31:0] alu_left4, alu_right4, wb_data4;
   logic        alu_cin4, wb_valid4;
   logic [35:0] alu_out4;

   // ARM-style ALU: returns {result, N, Z, C, V}; C/V are meaningless for logical ops.
   function automatic logic [35:0] alu_f(input logic [3:0] fn, input logic [31:0] a,
                                         input logic [31:0] b, input logic ci);
      logic [32:0] sum;
      logic [31:0] r, x, y;
      logic        cc, c, v, arith;
      arith = 1'b1;
      x = a; y = b; cc = 1'b0; r = 32'd0; c = 1'b0; v = 1'b1;
      case (fn)
         4'd2, 4'd10: begin y = ~b; cc = 1'b1; end
         4'd3:        begin x = b; y = ~a; cc = 1'b1; end
         4'd4, 4'd11: cc = 1'b0;
         4'd5:        cc = ci;
         4'd6:        begin y = ~b; cc = ci; end
         4'd7:        begin x = b; y = ~a; cc = ci; end
         4'd0, 4'd8:  begin arith = 1'b0; r = a & b; end
         4'd1, 4'd9:  begin arith = 1'b0; r = a ^ b; end
         4'd12:       begin arith = 1'b0; r = a | b; end
         4'd13:       begin arith = 1'b0; r = b; end
         4'd14:       begin arith = 1'b0; r = a & ~b; end
         default:     begin arith = 1'b0; r = ~b; end
      endcase
      if (arith) begin
         sum = {1'b0, x} + {1'b0, y} + {32'd0, cc};
         r = sum[31:0];
         c = sum[32];
         v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      return {r, r[31], (r == 32'd0), c, v};
   endfunction

   function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0: return z;           4'h1: return !z;
         4'h2: return c;           4'h3: return !c;
         4'h4: return n;           4'h5: return !n;
         4'h6: return v;           4'h7: return !v;
         4'h8: return c && !z;     4'h9: return !c || z;
         4'hA: return n == v;      4'hB: return n != v;
         4'hC: return !z && n == v; 4'hD: return z || n != v;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic vec_t ref_model(input vec_t t);
      vec_t        e;
      logic        ok, cmp, arith, upd;
      logic [35:0] a;
      e     = t;
      ok    = cond_model(t.cond, t.pre);
      a     = alu_f(t.op, t.rn, t.shop, t.pre[1]);
      cmp   = (t.op >= 4'd8) && (t.op <= 4'd11);
      arith = ((t.op >= 4'd2) && (t.op <= 4'd7)) || t.op == 4'd10 || t.op == 4'd11;
      upd   = t.s || cmp;
      e.exp_flags = t.pre;
      if (ok && upd) e.exp_flags = arith ? a[3:0] : {a[3], a[2], t.shc, t.pre[0]};
      else if (ok && t.ld_cap) e.exp_flags = 4'hF;
      e.exp_wb   = ok && !cmp;
      e.exp_data = a[35:4];
      e.exp_done = !ok ? 1 : (cmp ? 1 + W : 2 + W + t.dly);
      return e;
   endfunction

   always_comb alu_out  = alu_f(alu_fn, alu_left, alu_right, alu_cin);
   always_comb alu_out4 = alu_f(alu_fn4, alu_left4, alu_right4, alu_cin4);
   assign alu_res = alu_out[35:4];
   assign {alu_n, alu_z, alu_c, alu_v} = alu_out[3:0];

   alu_sequencer #(.ALU_WAIT(W), .FLAGS_RST(4'b0000)) u_dut (
      .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_COND(req_cond), .REQ_OPCODE(req_opcode), .REQ_S(req_s), .REQ_RD(req_rd),
      .REQ_RN(req_rn), .REQ_SHOP(req_shop), .REQ_SHC(req_shc),
      .ALU_FN(alu_fn), .ALU_LEFT(alu_left), .ALU_RIGHT(alu_right), .ALU_CIN(alu_cin),
      .ALU_RES(alu_res), .ALU_N(alu_n), .ALU_Z(alu_z), .ALU_C(alu_c), .ALU_V(alu_v),
      .WB_VALID(wb_valid), .WB_READY(wb_ready), .WB_RD(wb_rd), .WB_DATA(wb_data),
      .FLAGS(flags), .FLAGS_LD(flags_ld), .FLAGS_IN(flags_in), .DONE(done), .BUSY(busy)
   );

   alu_sequencer #(.ALU_WAIT(W4), .FLAGS_RST(4'b0101)) u_dut4 (
      .CLK(clk), .RST(rst4), .REQ_VALID(req_valid4), .REQ_READY(req_ready4),
      .REQ_COND(req_cond), .REQ_OPCODE(req_opcode), .REQ_S(req_s), .REQ_RD(req_rd),
      .REQ_RN(req_rn), .REQ_SHOP(req_shop), .REQ_SHC(req_shc),
      .ALU_FN(alu_fn4), .ALU_LEFT(alu_left4), .ALU_RIGHT(alu_right4), .ALU_CIN(alu_cin4),
      .ALU_RES(alu_out4[35:4]), .ALU_N(alu_out4[3]), .ALU_Z(alu_out4[2]),
      .ALU_C(alu_out4[1]), .ALU_V(alu_out4[0]),
      .WB_VALID(wb_valid4), .WB_READY(wb_ready4), .WB_RD(wb_rd4), .WB_DATA(wb_data4),
      .FLAGS(flags4), .FLAGS_LD(flags_ld4), .FLAGS_IN(flags_in4), .DONE(done4), .BUSY(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input string tag, input vec_t v);
      int          first_wb, done_n, done_cnt, seen;
      logic        bad_stab, bad_busy;
      logic [31:0] d0;
      logic [3:0]  r0;
      @(negedge clk);
      flags_ld = 1'b1;
      flags_in = v.pre;
      @(negedge clk);
      flags_ld = 1'b0;
      check({tag, ".preset"}, 64'(flags), 64'(v.pre));
      check({tag, ".ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_cond = v.cond; req_opcode = v.op; req_s = v.s; req_rd = v.rd;
      req_rn = v.rn; req_shop = v.shop; req_shc = v.shc;
      @(posedge clk);
      #1 req_valid = 1'b0;
      first_wb = -1; done_n = -1; done_cnt = 0; seen = 0; bad_stab = 1'b0; bad_busy = 1'b0;
      d0 = '0; r0 = '0;
      for (int n = 1; n <= 40 && done_n < 0; n++) begin
         @(negedge clk);
         wb_ready = wb_valid && (seen >= v.dly);
         flags_ld = v.ld_cap && (n == 1 + W);
         flags_in = 4'hF;
         #1;
         if (n == 1) begin
            check({tag, ".alu_fn"}, 64'(alu_fn), 64'(v.op));
            check({tag, ".alu_ops"}, {alu_left, alu_right}, {v.rn, v.shop});
         end
         if (!busy || req_ready) bad_busy = 1'b1;
         if (wb_valid) begin
            if (first_wb < 0) begin
               first_wb = n; d0 = wb_data; r0 = wb_rd;
            end else if ({wb_data, wb_rd} != {d0, r0}) begin
               bad_stab = 1'b1;
            end
            seen++;
         end
         if (done) begin
            done_cnt++;
            done_n = n;
         end
      end
      @(posedge clk);
      #1 wb_ready = 1'b0;
      flags_ld = 1'b0;
      @(negedge clk);
      if (done) done_cnt++;
      check({tag, ".done_cycle"}, 64'(done_n), 64'(v.exp_done));
      check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
      check({tag, ".wb_first"}, 64'(first_wb), v.exp_wb ? 64'(2 + W) : 64'(-1));
      if (v.exp_wb) begin
         check({tag, ".wb_data"}, 64'(d0), 64'(v.exp_data));
         check({tag, ".wb_rd"}, 64'(r0), 64'(v.rd));
      end
      check({tag, ".wb_stable"}, 64'(bad_stab), 64'd0);
      check({tag, ".busy"}, 64'(bad_busy), 64'd0);
      check({tag, ".flags"}, 64'(flags), 64'(v.exp_flags));
      check({tag, ".idle"}, {62'd0, busy, wb_valid}, 64'd0);
   endtask

   vec_t vecs[12];
   vec_t rv;

   initial begin
      int first_wb, done_n;
      logic bad;
      logic [31:0] d0;
      rst = 1'b0; rst4 = 1'b0;
      req_valid = 1'b0; req_valid4 = 1'b0; req_cond = '0; req_opcode = '0; req_s = 1'b0;
      req_rd = '0; req_rn = '0; req_shop = '0; req_shc = 1'b0;
      wb_ready = 1'b0; wb_ready4 = 1'b1; flags_ld = 1'b0; flags_in = '0;
      flags_ld4 = 1'b0; flags_in4 = '0;

      //        pre   cond  op    s  rd    rn            shop          shc dly ld wb data          flg done
      vecs[0]  = '{4'h0, 4'hE, 4'h4, 1, 4'h3, 32'h7FFFFFFF, 32'h1,        0, 0, 0, 1, 32'h80000000, 4'h9, 3};
      vecs[1]  = '{4'h0, 4'hE, 4'hA, 0, 4'h2, 32'h5,        32'h5,        0, 0, 0, 0, 32'h0,        4'h6, 2};
      vecs[2]  = '{4'h0, 4'h0, 4'hD, 1, 4'h4, 32'h0,        32'h1234,     0, 0, 0, 0, 32'h0,        4'h0, 1};
      vecs[3]  = '{4'hA, 4'hE, 4'hC, 0, 4'h7, 32'hF0F00000, 32'hF,        0, 3, 0, 1, 32'hF0F0000F, 4'hA, 6};
      vecs[4]  = '{4'h1, 4'hE, 4'h0, 1, 4'h5, 32'hFF00,     32'hFF,       1, 0, 1, 1, 32'h0,        4'h7, 3};
      vecs[5]  = '{4'h0, 4'hE, 4'h2, 1, 4'h1, 32'h3,        32'h5,        0, 0, 0, 1, 32'hFFFFFFFE, 4'h8, 3};
      vecs[6]  = '{4'h2, 4'hE, 4'h5, 1, 4'h6, 32'h1,        32'h1,        0, 1, 0, 1, 32'h3,        4'h0, 4};
      vecs[7]  = '{4'h0, 4'h1, 4'h8, 0, 4'h8, 32'hF0,       32'hF,        1, 0, 0, 0, 32'h0,        4'h6, 2};
      vecs[8]  = '{4'hF, 4'hF, 4'h4, 1, 4'h9, 32'h1,        32'h1,        0, 0, 0, 0, 32'h0,        4'hF, 1};
      vecs[9]  = '{4'h4, 4'hA, 4'hF, 0, 4'hF, 32'h0,        32'h0,        0, 2, 0, 1, 32'hFFFFFFFF, 4'h4, 5};
      vecs[10] = '{4'h0, 4'hE, 4'h3, 1, 4'h0, 32'h1,        32'h0,        0, 0, 0, 1, 32'hFFFFFFFF, 4'h8, 3};
      vecs[11] = '{4'h0, 4'hB, 4'h4, 1, 4'h3, 32'h1,        32'h1,        0, 0, 0, 0, 32'h0,        4'h0, 1};

      #1 rst = 1'b1; rst4 = 1'b1;
      #1;
      check("rst.flags", 64'(flags), 64'h0);
      check("rst.flags4", 64'(flags4), 64'h5);
      check("rst.ctl", {61'd0, busy, wb_valid, done}, 64'd0);
      check("rst.alu", {alu_left, alu_right}, 64'd0);
      check("rst.fn_cin_rd", {55'd0, alu_fn, alu_cin, wb_rd}, 64'd0);
      check("rst.wb_data", 64'(wb_data), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; rst4 = 1'b0;
      #1 check("rst.ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < 12; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

      for (int i = 0; i < 60; i++) begin
         rv.pre = 4'($urandom); rv.cond = 4'($urandom); rv.op = 4'($urandom);
         rv.s = 1'($urandom); rv.rd = 4'($urandom); rv.shc = 1'($urandom);
         rv.rn = $urandom; rv.shop = ($urandom_range(0, 3) == 0) ? rv.rn : $urandom;
         rv.dly = $urandom_range(0, 2); rv.ld_cap = 1'($urandom);
         run_txn($sformatf("rnd%0d", i), ref_model(rv));
      end

      // Long-wait instance: reset lands in EXEC, then a clean transaction.
      @(negedge clk);
      flags_ld4 = 1'b1; flags_in4 = 4'hC;
      @(negedge clk);
      flags_ld4 = 1'b0;
      check("w4.preset", 64'(flags4), 64'hC);
      req_cond = 4'hE; req_opcode = 4'h4; req_s = 1'b1; req_rd = 4'h2;
      req_rn = 32'd10; req_shop = 32'd20; req_shc = 1'b0;
      req_valid4 = 1'b1;
      @(posedge clk);
      #1 req_valid4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst4 = 1'b1;
      #1;
      check("w4.rst_flags", 64'(flags4), 64'h5);
      check("w4.rst_ctl", {61'd0, busy4, wb_valid4, done4}, 64'd0);
      check("w4.rst_fn", 64'(alu_fn4), 64'd0);
      @(negedge clk);
      rst4 = 1'b0;
      bad = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done4 || wb_valid4 || busy4) bad = 1'b1;
      end
      check("w4.discarded", 64'(bad), 64'd0);
      check("w4.ready", 64'(req_ready4), 64'd1);
      req_valid4 = 1'b1;
      @(posedge clk);
      #1 req_valid4 = 1'b0;
      first_wb = -1; done_n = -1; d0 = '0;
      for (int n = 1; n <= 20 && done_n < 0; n++) begin
         @(negedge clk);
         if (wb_valid4 && first_wb < 0) begin
            first_wb = n; d0 = wb_data4;
         end
         if (done4) done_n = n;
      end
      check("w4.wb_first", 64'(first_wb), 64'(W4 + 2));
      check("w4.done_cycle", 64'(done_n), 64'(W4 + 2));
      check("w4.wb_data", 64'(d0), 64'd30);
      @(negedge clk);
      check("w4.flags", 64'(flags4), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
